// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - request/response bus between CPU memory stage and mem_responder
interface mem_responder_if;
    logic        i_req;
    logic        i_we;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [3:0]  i_be;
    logic        o_ready;
    logic        o_valid;
    logic [31:0] o_data;
    logic        o_err;

    modport master (
        output i_req, i_we, i_addr, i_wdata, i_be,
        input  o_ready, o_valid, o_data, o_err
    );

    modport slave (
        input  i_req, i_we, i_addr, i_wdata, i_be,
        output o_ready, o_valid, o_data, o_err
    );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency word memory with byte enables and misalignment error
module mem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    mem_responder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t              state;
    logic [3:0]          cnt;
    logic                ready_q;
    logic                valid_q;
    logic                err_q;
    logic [31:0]         data_q;

    logic                cap_we;
    logic                cap_err;
    logic [ADDR_W-1:0]   cap_idx;
    logic [31:0]         cap_wdata;
    logic [3:0]          cap_be;

    logic [31:0]         mem [0:(1<<ADDR_W)-1];
    logic [31:0]         cur_word;
    logic [31:0]         merged;

    // Address bits above the word index alias onto the same memory.
    logic                unused_addr_hi;
    assign unused_addr_hi = ^bus.i_addr[31:ADDR_W+2];

    assign bus.o_ready = ready_q;
    assign bus.o_valid = valid_q;
    assign bus.o_err   = err_q;
    assign bus.o_data  = data_q;

    // Current word at the captured index with the enabled write lanes overlaid.
    always_comb begin
        cur_word = mem[cap_idx];
        merged   = cur_word;
        for (int k = 0; k < 4; k++) begin
            if (cap_be[k]) begin
                merged[8*k +: 8] = cap_wdata[8*k +: 8];
            end
        end
    end

    // Control FSM: capture on accept, count latency, present one response cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            data_q    <= 32'h0;
            cap_we    <= 1'b0;
            cap_err   <= 1'b0;
            cap_idx   <= '0;
            cap_wdata <= 32'h0;
            cap_be    <= 4'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_req) begin
                        cap_we    <= bus.i_we;
                        cap_err   <= |bus.i_addr[1:0];
                        cap_idx   <= bus.i_addr[ADDR_W+1:2];
                        cap_wdata <= bus.i_wdata;
                        cap_be    <= bus.i_be;
                        cnt       <= 4'(LATENCY - 1);
                        ready_q   <= 1'b0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        state   <= RESP;
                        valid_q <= 1'b1;
                        err_q   <= cap_err;
                        if (cap_err) begin
                            data_q <= 32'h0;
                        end else if (cap_we) begin
                            data_q <= merged;
                        end else begin
                            data_q <= cur_word;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    err_q   <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

    // Write commit on leaving RESP; data_q already holds the merged word.
    // An async reset forces IDLE first, so an aborted access never writes.
    always_ff @(posedge i_clk) begin
        if (state == RESP && cap_we && !cap_err) begin
            mem[cap_idx] <= data_q;
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder
module tb_mem_responder;
    localparam int ADDR_W  = 8;
    localparam int LATENCY = 2;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    always #5 i_clk = ~i_clk;

    mem_responder_if bus ();

    mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          acc;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[14];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge i_clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor: every o_valid pulse must match the oldest expected entry.
    always @(posedge i_clk) begin
        #1;
        if (bus.o_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid: got o_valid=1 expected no response (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("resp_data", bus.o_data, mon_e.data);
                check("resp_err", {31'b0, bus.o_err}, {31'b0, mon_e.err});
                check("resp_latency", 32'(cyc - mon_e.acc), 32'(LATENCY));
            end
        end
    end

    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input logic [31:0] ed, input logic ee,
                          input bit expect_resp);
        int n = 0;
        bus.i_req   = 1'b1;
        bus.i_we    = we;
        bus.i_addr  = addr;
        bus.i_wdata = wdata;
        bus.i_be    = be;
        while (bus.o_ready !== 1'b1 && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        check("accept_ready", {31'b0, bus.o_ready}, 32'd1);
        if (bus.o_ready === 1'b1 && expect_resp) begin
            sb.push_back('{ed, ee, cyc + 1});
        end
        @(negedge i_clk);
        bus.i_req   = 1'b0;
        bus.i_we    = 1'($urandom);
        bus.i_addr  = $urandom;
        bus.i_wdata = $urandom;
        bus.i_be    = 4'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge i_clk);
            n++;
        end
        check("drain_pending", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    logic [31:0] clist [3];
    int acc_cnt;
    int last_acc;

    initial begin
        vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 1'b0};
        vecs[1]  = '{1'b0, 32'h10,  32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h20,  32'h11223344, 4'hF, 32'h11223344, 1'b0};
        vecs[3]  = '{1'b1, 32'h20,  32'hAABBCCDD, 4'h5, 32'h11BB33DD, 1'b0};
        vecs[4]  = '{1'b0, 32'h20,  32'h0,        4'hF, 32'h11BB33DD, 1'b0};
        vecs[5]  = '{1'b0, 32'h13,  32'h0,        4'hF, 32'h0,        1'b1};
        vecs[6]  = '{1'b0, 32'h10,  32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
        vecs[7]  = '{1'b1, 32'h10,  32'h12345678, 4'h0, 32'hDEADBEEF, 1'b0};
        vecs[8]  = '{1'b0, 32'h10,  32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
        vecs[9]  = '{1'b1, 32'h22,  32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
        vecs[10] = '{1'b0, 32'h20,  32'h0,        4'hF, 32'h11BB33DD, 1'b0};
        vecs[11] = '{1'b1, 32'h400, 32'h5,        4'hF, 32'h5,        1'b0};
        vecs[12] = '{1'b0, 32'h000, 32'h0,        4'hF, 32'h5,        1'b0};
        vecs[13] = '{1'b1, 32'h40,  32'hCAFEF00D, 4'hF, 32'hCAFEF00D, 1'b0};

        bus.i_req = 1'b0; bus.i_we = 1'b0; bus.i_addr = 32'h0; bus.i_wdata = 32'h0; bus.i_be = 4'h0;
        repeat (2) @(negedge i_clk);
        check("reset_ready", {31'b0, bus.o_ready}, 32'd1);
        check("reset_valid", {31'b0, bus.o_valid}, 32'd0);
        check("reset_err", {31'b0, bus.o_err}, 32'd0);
        check("reset_data", bus.o_data, 32'h0);

        // First request is presented right as reset releases.
        i_rst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                   vecs[i].exp_data, vecs[i].exp_err, 1'b1);
        end
        drain();

        repeat (3) @(negedge i_clk);
        check("hold_data", bus.o_data, 32'hCAFEF00D);
        check("hold_valid", {31'b0, bus.o_valid}, 32'd0);

        // Request held high: accepts only from IDLE; BUSY-time writes must be ignored.
        clist[0] = 32'h10; clist[1] = 32'h20; clist[2] = 32'h0;
        acc_cnt = 0;
        last_acc = -1;
        for (int i = 0; i < 12; i++) begin
            bus.i_req = 1'b1;
            if (bus.o_ready === 1'b1) begin
                bus.i_we    = 1'b0;
                bus.i_addr  = clist[acc_cnt % 3];
                bus.i_wdata = 32'h0;
                bus.i_be    = 4'hF;
                sb.push_back('{(acc_cnt % 3 == 0) ? 32'hDEADBEEF :
                               (acc_cnt % 3 == 1) ? 32'h11BB33DD : 32'h5, 1'b0, cyc + 1});
                if (last_acc >= 0) check("accept_gap", 32'(cyc + 1 - last_acc), 32'd4);
                last_acc = cyc + 1;
                acc_cnt++;
            end else begin
                bus.i_we    = 1'b1;
                bus.i_addr  = 32'h10;
                bus.i_wdata = 32'h0;
                bus.i_be    = 4'hF;
            end
            @(negedge i_clk);
        end
        bus.i_req = 1'b0;
        check("accept_count", 32'(acc_cnt), 32'd3);
        drain();

        // Reset in BUSY aborts the write; first edge after release accepts.
        access(1'b1, 32'h40, 32'h0BAD0BAD, 4'hF, 32'h0, 1'b0, 1'b0);
        i_rst_n = 1'b0;
        #1;
        check("abort_ready", {31'b0, bus.o_ready}, 32'd1);
        check("abort_valid", {31'b0, bus.o_valid}, 32'd0);
        check("abort_data", bus.o_data, 32'h0);
        #2;
        i_rst_n = 1'b1;
        access(1'b0, 32'h40, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0, 1'b1);
        access(1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 1'b1);
        drain();
        repeat (4) @(negedge i_clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, giving log2 of the memory depth in 32-bit words (256 words).
REQ-002 The block SHALL have parameter LATENCY, default 2, giving the number of cycles from request accept to response, legal range 1..15.
REQ-003 Port i_clk SHALL be an input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-004 Port i_rst_n SHALL be an input, 1 bit, the reset: asynchronous and active-low.
REQ-005 Port i_req SHALL be an input, 1 bit, carrying the request strobe from the CPU memory-access stage.
REQ-006 Port i_we SHALL be an input, 1 bit, selecting the operation: 1 = write, 0 = read.
REQ-007 Port i_addr SHALL be an input, 32 bits, carrying the byte address; word index = i_addr[ADDR_W+1:2], and higher bits are ignored (aliasing).
REQ-008 Port i_wdata SHALL be an input, 32 bits, carrying the write data.
REQ-009 Port i_be SHALL be an input, 4 bits, carrying byte enables; bit k enables byte lane [8k+7:8k].
REQ-010 Port o_ready SHALL be an output, 1 bit, indicating the responder can accept a request this cycle.
REQ-011 Port o_valid SHALL be an output, 1 bit, a one-cycle pulse marking the response cycle.
REQ-012 Port o_data SHALL be an output, 32 bits, carrying the response data, registered and held between responses.
REQ-013 Port o_err SHALL be an output, 1 bit, flagging a misaligned access; it is valid only while o_valid=1.

Function
REQ-014 The FSM SHALL have exactly three states, IDLE, BUSY and RESP, with o_ready=1 only in IDLE.
REQ-015 A request SHALL be accepted on a rising edge where i_req=1 and o_ready=1; i_we, i_addr, i_wdata and i_be SHALL be captured at that same edge, so inputs may change afterwards.
REQ-016 i_req while o_ready=0 SHALL be ignored with no side effects; the request is not queued.
REQ-017 On accept, the FSM SHALL move IDLE->BUSY and load a down-counter with LATENCY-1.
REQ-018 In BUSY, the counter SHALL decrement each cycle, and the FSM SHALL move BUSY->RESP at the edge where the counter equals 0; with LATENCY=1 the FSM passes through BUSY for exactly one cycle.
REQ-019 With accept at edge t0, o_valid SHALL be 1 from edge t0+LATENCY to edge t0+LATENCY+1, and o_ready SHALL return to 1 at edge t0+LATENCY+1 (RESP->IDLE unconditionally).
REQ-020 For a read, o_data SHALL be loaded at entry to RESP with mem[word index].
REQ-021 For a write, each enabled byte lane SHALL be committed to memory at the RESP->IDLE edge, and o_data SHALL be loaded with the merged post-write word.
REQ-022 A write with i_be=4'b0000 SHALL leave memory unchanged and return the current word.
REQ-023 A misaligned access (captured i_addr[1:0] != 0) SHALL perform no memory read or write and SHALL respond after the same latency with o_err=1 and o_data=32'h0; o_err SHALL be 0 for aligned accesses.
REQ-024 o_data SHALL hold its last value outside RESP, so a downstream register may sample it late.
REQ-025 A read issued immediately after a write to the same word SHALL return the written data (no hazard, since the write commits before the next accept).

Reset
REQ-026 While i_rst_n=0, the block SHALL force the FSM to IDLE, the counter to 0, o_ready=1, o_valid=0, o_err=0 and o_data=32'h0, asynchronously without waiting for a clock edge.
REQ-027 A reset asserted in BUSY or RESP SHALL abort the access: no response is produced and no memory write occurs.
REQ-028 Memory array contents SHALL NOT be affected by reset.
REQ-029 The first accept SHALL be possible at the first rising edge after i_rst_n deasserts.

Verification
REQ-030 The bench SHALL check: write addr 0x10, wdata 0xDEADBEEF, be 4'hF, then read 0x10 -> o_valid pulses exactly LATENCY cycles after each accept; the read returns o_data=0xDEADBEEF.
REQ-031 The bench SHALL check: memory word at 0x20 = 0x11223344, write 0xAABBCCDD with be 4'b0101 -> response and subsequent read both give 0x11BB33DD.
REQ-032 The bench SHALL check: read at 0x13 -> o_valid=1, o_err=1, o_data=0; a read of word 0x10 is unchanged afterwards.
REQ-033 The bench SHALL check: i_req held high continuously with LATENCY=2 -> accepts every 4th cycle (IDLE, BUSY, BUSY, RESP); inputs presented during BUSY are not serviced.
REQ-034 The bench SHALL check: write to 0x40 accepted, then i_rst_n pulsed low in BUSY -> o_valid never pulses; o_ready=1 immediately; a later read of 0x40 shows the old value.
REQ-035 The bench SHALL check: with ADDR_W=8, write 0x5 to 0x400 then read 0x000 -> returns 0x5 (aliasing).
